// File: rtl/xif_mem_responder.sv
// CORE-V-XIF memory responder: word RAM plus a fixed-latency, in-order result pipe.
// Optional build macro XIF_MEM_ERR_INJECT_EN adds an address-matched bus-error injection port.
module xif_mem_responder #(
   parameter int X_ID_WIDTH      = 4,
   parameter int MEM_DEPTH       = 256,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [X_ID_WIDTH-1:0] mem_req_id,
   input  logic [31:0]           mem_req_addr,
   input  logic [31:0]           mem_req_wdata,
   input  logic                  mem_req_we,
   input  logic [3:0]            mem_req_be,
   input  logic [2:0]            mem_req_size,
`ifdef XIF_MEM_ERR_INJECT_EN
   input  logic                  err_inject_valid,
   input  logic [31:0]           err_inject_addr,
`endif
   output logic                  mem_resp_exc,
   output logic [5:0]            mem_resp_exccode,
   output logic                  mem_result_valid,
   output logic [X_ID_WIDTH-1:0] mem_result_id,
   output logic [31:0]           mem_result_rdata,
   output logic                  mem_result_err
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]           mem [MEM_DEPTH];
   logic [AW-1:0]         word_idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  hs;
   logic                  accept;
   logic                  inj_hit;
   logic                  do_write;
   logic [31:0]           load_data;
   logic [CW-1:0]         outstanding;

   logic [LATENCY-1:0]    pipe_valid;
   logic [LATENCY-1:0]    pipe_err;
   logic [X_ID_WIDTH-1:0] pipe_id    [LATENCY];
   logic [31:0]           pipe_rdata [LATENCY];

   assign word_idx     = mem_req_addr[AW+1:2];
   assign misaligned   = (mem_req_size != 3'd2) || (mem_req_addr[1:0] != 2'b00);
   assign out_of_range = ({2'b00, mem_req_addr[31:2]} >= 32'(MEM_DEPTH));

   // Response is held at zero outside a valid request and while reset is asserted.
   always_comb begin
      mem_resp_exc     = 1'b0;
      mem_resp_exccode = 6'd0;
      if (rst && mem_valid) begin
         if (misaligned) begin
            mem_resp_exc     = 1'b1;
            mem_resp_exccode = mem_req_we ? 6'd6 : 6'd4;
         end else if (out_of_range) begin
            mem_resp_exc     = 1'b1;
            mem_resp_exccode = mem_req_we ? 6'd7 : 6'd5;
         end
      end
   end

   assign mem_ready = rst && !stall && (outstanding < CW'(MAX_OUTSTANDING));
   assign hs        = mem_valid && mem_ready;
   assign accept    = hs && !mem_resp_exc;

`ifdef XIF_MEM_ERR_INJECT_EN
   assign inj_hit = err_inject_valid && (mem_req_addr[31:2] == err_inject_addr[31:2]);
`else
   assign inj_hit = 1'b0;
`endif

   assign do_write  = accept && mem_req_we && !inj_hit;
   assign load_data = (mem_req_we || inj_hit) ? 32'd0 : mem[word_idx];

   // RAM has no reset so stored data survives rst.
   always_ff @(posedge ck) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_req_be[b]) begin
               mem[word_idx][8*b +: 8] <= mem_req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_id[i]    <= '0;
            pipe_rdata[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && inj_hit;
         pipe_id[0]    <= accept ? mem_req_id : '0;
         pipe_rdata[0] <= accept ? load_data : 32'd0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_id[i]    <= pipe_id[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
         end
      end
   end

   assign mem_result_valid = pipe_valid[LATENCY-1];
   assign mem_result_err   = pipe_err[LATENCY-1];
   assign mem_result_id    = pipe_id[LATENCY-1];
   assign mem_result_rdata = pipe_rdata[LATENCY-1];

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         outstanding <= '0;
      end else begin
         case ({accept, mem_result_valid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_xif_mem_responder.sv
// Randomized scoreboard bench for xif_mem_responder; results are checked by an independent monitor.
module tb_xif_mem_responder;
   localparam int IDW = 4, DEPTH = 256, LAT = 6, MAXO = 4;

   logic           ck = 1'b0, rst = 1'b0, stall = 1'b0, mem_valid = 1'b0;
   logic           mem_ready, mem_resp_exc, mem_result_valid, mem_result_err;
   logic [IDW-1:0] mem_req_id = '0, mem_result_id;
   logic [31:0]    mem_req_addr = '0, mem_req_wdata = '0, mem_result_rdata;
   logic           mem_req_we = 1'b0;
   logic [3:0]     mem_req_be = '0;
   logic [2:0]     mem_req_size = 3'd2;
   logic [5:0]     mem_resp_exccode;
   logic           inj_on = 1'b0;
   logic [31:0]    inj_addr = '0;

   xif_mem_responder #(.X_ID_WIDTH(IDW), .MEM_DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .ck(ck), .rst(rst), .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_size(mem_req_size),
`ifdef XIF_MEM_ERR_INJECT_EN
      .err_inject_valid(inj_on), .err_inject_addr(inj_addr),
`endif
      .mem_resp_exc(mem_resp_exc), .mem_resp_exccode(mem_resp_exccode),
      .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
      .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err));

   always #5 ck = ~ck;

   int cyc = 0;
   always @(posedge ck) cyc++;

   int n_vec = 0, n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    rdata;
      logic           err;
      int             cyc;
   } exp_t;

   exp_t        sb[$];
   int          inflight[$];
   logic [31:0] model_mem [16];

   // Monitor: compares every presented result against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge ck);
         #1;
         if (rst) begin
            if (mem_result_valid) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_result: got id %0h, expected no result", mem_result_id);
               end else begin
                  e = sb.pop_front();
                  chk("result_cycle", 32'(cyc), 32'(e.cyc));
                  chk("result_id", 32'(mem_result_id), 32'(e.id));
                  chk("result_rdata", mem_result_rdata, e.rdata);
                  chk("result_err", 32'(mem_result_err), 32'(e.err));
               end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               n_vec++;
               n_err++;
               $display("FAIL missing_result: got no result, expected id %0h in cycle %0d", e.id, e.cyc);
            end
         end
      end
   end

   // One request cycle: inputs applied after the edge, checks and model update at the falling edge.
   task automatic drive_cycle(input logic v, input logic st, input logic [IDW-1:0] id,
                              input logic [31:0] addr, input logic [31:0] wd, input logic we,
                              input logic [3:0] be, input logic [2:0] size, output logic acc);
      logic       exp_ready, exp_exc;
      logic [5:0] exp_code;
      int         w;
      exp_t       e;
      stall = st; mem_valid = v; mem_req_id = id; mem_req_addr = addr;
      mem_req_wdata = wd; mem_req_we = we; mem_req_be = be; mem_req_size = size;
      @(negedge ck);
      while (inflight.size() > 0 && inflight[0] < cyc) void'(inflight.pop_front());
      exp_ready = !st && (inflight.size() < MAXO);
      chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
      exp_exc = 1'b0;
      exp_code = 6'd0;
      if (v) begin
         if (size != 3'd2 || addr[1:0] != 2'b00) begin
            exp_exc = 1'b1;
            exp_code = we ? 6'd6 : 6'd4;
         end else if (int'(addr[31:2]) >= DEPTH) begin
            exp_exc = 1'b1;
            exp_code = we ? 6'd7 : 6'd5;
         end
      end
      chk("resp_exc", 32'(mem_resp_exc), 32'(exp_exc));
      chk("resp_exccode", 32'(mem_resp_exccode), 32'(exp_code));
      acc = v && exp_ready;
      if (acc && !exp_exc) begin
         w = int'(addr[31:2]);
         e.id = id;
         e.cyc = cyc + LAT;
         e.err = inj_on && (addr[31:2] == inj_addr[31:2]);
         e.rdata = 32'd0;
         if (!e.err) begin
            if (we) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
               e.rdata = model_mem[w];
            end
         end
         sb.push_back(e);
         inflight.push_back(cyc + LAT);
      end
      @(posedge ck);
      #1;
   endtask

   task automatic send(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic [3:0] be);
      logic acc;
      int   t = 0;
      do begin
         drive_cycle(1'b1, 1'b0, id, addr, wd, we, be, 3'd2, acc);
         t++;
      end while (!acc && t < 50);
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got no handshake, expected one within 50 cycles");
      end
   endtask

   task automatic idle();
      logic acc;
      drive_cycle(1'b0, 1'b0, '0, 32'd0, 32'd0, 1'b0, 4'h0, 3'd2, acc);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 100) begin
         idle();
         t++;
      end
      idle();
      if (sb.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic        acc, v, st, we;
      logic [31:0] addr;
      logic [2:0]  size;
      int          kind;

      #12;
      chk("reset_result_valid", 32'(mem_result_valid), 32'd0);
      chk("reset_mem_ready", 32'(mem_ready), 32'd0);
      chk("reset_result_rdata", mem_result_rdata, 32'd0);
      #10 rst = 1'b1;
      @(posedge ck);
      #1;

      for (int w = 0; w < 16; w++)
         send(IDW'(w), 32'(w * 4), (w == 3) ? 32'hDEADBEEF : (w == 4) ? 32'h11223344 : $urandom, 1'b1, 4'hF);
      drain();

      // Load latency, then byte-enabled store followed by read-after-write.
      send(4'd5, 32'h0000000C, 32'd0, 1'b0, 4'hF);
      drain();
      send(4'd1, 32'h00000010, 32'hAABBCCDD, 1'b1, 4'b0101);
      send(4'd2, 32'h00000010, 32'd0, 1'b0, 4'hF);
      drain();

      drive_cycle(1'b1, 1'b0, 4'd3, 32'h00000002, 32'd0, 1'b0, 4'hF, 3'd2, acc);
      drive_cycle(1'b1, 1'b0, 4'd4, 32'h00000400, 32'h1234, 1'b1, 4'hF, 3'd2, acc);
      drive_cycle(1'b1, 1'b0, 4'd6, 32'h00000008, 32'h1234, 1'b1, 4'hF, 3'd1, acc);
      idle();
      drain();

      // Credit limit: valid held high with long latency.
      for (int i = 0; i < 24; i++)
         drive_cycle(1'b1, 1'b0, IDW'(i), 32'($urandom_range(0, 15) * 4), 32'd0, 1'b0, 4'hF, 3'd2, acc);
      drain();

      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(0, 9) < 7);
         st = ($urandom_range(0, 9) < 2);
         we = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 19);
         size = 3'd2;
         addr = 32'($urandom_range(0, 15) * 4);
         if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
         else if (kind == 1) addr = 32'($urandom_range(DEPTH, 100000)) << 2;
         else if (kind == 2) size = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 1));
         drive_cycle(v, st, IDW'($urandom), addr, $urandom, we, 4'($urandom), size, acc);
      end
      drain();

      // Reset with three loads in flight.
      send(4'd7, 32'h00000004, 32'd0, 1'b0, 4'hF);
      send(4'd8, 32'h0000000C, 32'd0, 1'b0, 4'hF);
      send(4'd9, 32'h00000010, 32'd0, 1'b0, 4'hF);
      mem_valid = 1'b1; mem_req_addr = 32'h2; mem_req_we = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("midreset_result_valid", 32'(mem_result_valid), 32'd0);
      chk("midreset_result_id", 32'(mem_result_id), 32'd0);
      chk("midreset_mem_ready", 32'(mem_ready), 32'd0);
      chk("midreset_resp_exc", 32'(mem_resp_exc), 32'd0);
      sb.delete();
      inflight.delete();
      mem_valid = 1'b0;
      repeat (3) @(posedge ck);
      #3 rst = 1'b1;
      @(posedge ck);
      #1;
      for (int i = 0; i < LAT + 4; i++) idle();
      for (int w = 0; w < 16; w++) send(IDW'(w), 32'(w * 4), 32'd0, 1'b0, 4'hF);
      drain();

`ifdef XIF_MEM_ERR_INJECT_EN
      inj_on = 1'b1;
      inj_addr = 32'h20;
      send(4'd10, 32'h20, 32'h55, 1'b1, 4'hF);
      send(4'd11, 32'h20, 32'd0, 1'b0, 4'hF);
      drain();
      inj_on = 1'b0;
      send(4'd12, 32'h20, 32'd0, 1'b0, 4'hF);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
